odo_round_key_sequencer: RTL and testbench
==========================================

ODO_ROUND_KEY_SEQUENCER -- requirements
Module: odo_round_key_sequencer

Interface
REQ-001 SHALL have parameter KEY_W, default 10, round-key width.
REQ-002 SHALL have parameter PERIOD_W, default 4, period-index width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  sequence request, sampled only in IDLE.
REQ-006 SHALL have port base_period  input  PERIOD_W  first period index; legal 0..8.
REQ-007 SHALL have port num_rounds  input  5  keys to deliver, 0..31.
REQ-008 SHALL have port abort  input  1  cancel the active sequence.
REQ-009 SHALL have port rom_period  output  PERIOD_W  index driven to the external registered key ROM.
REQ-010 SHALL have port rom_key  input  KEY_W  ROM data, valid one clk after rom_period changes.
REQ-011 SHALL have port key  output  KEY_W  captured round key.
REQ-012 SHALL have port key_period  output  PERIOD_W  period index tagging key.
REQ-013 SHALL have port key_valid / key_ready  output / input  1 each  consumer handshake.
REQ-014 SHALL have port key_last  output  1  high with the final key of a sequence.
REQ-015 SHALL have ports busy, done, err  output  1 each  status; done and err are 1-cycle pulses.

Function
REQ-016 SHALL implement states IDLE, FETCH, WAIT, PRESENT, DONE.
REQ-017 IDLE with start=1 and base_period<=8 and num_rounds>0 SHALL latch both inputs and go to FETCH; busy=1 from the next cycle.
REQ-018 IDLE with start=1 and base_period>8 SHALL pulse err for one cycle, stay IDLE, and leave rom_period unchanged.
REQ-019 IDLE with start=1, legal period and num_rounds=0 SHALL go to DONE, pulsing done in the next cycle with no key_valid.
REQ-020 FETCH SHALL drive rom_period=current period and go to WAIT.
REQ-021 WAIT SHALL capture rom_key into key and the period into key_period, then go to PRESENT.
REQ-022 PRESENT SHALL hold key_valid=1 with key, key_period and key_last stable until key_valid&key_ready.
REQ-023 On handshake, non-final round SHALL advance period and go to FETCH; final round SHALL go to DONE.
REQ-024 First key_valid SHALL rise 3 cycles after the start-sampling edge; each later key 3 cycles after the previous handshake.
REQ-025 Period advance SHALL wrap modulo 9: 8 -> 0, otherwise +1.
REQ-026 key_last SHALL be 1 exactly when the presented key is round num_rounds-1.
REQ-027 DONE SHALL pulse done for one cycle, drop busy, and return to IDLE.
REQ-028 abort in any non-IDLE state SHALL return to IDLE next cycle, clearing key_valid and busy, with no done pulse; abort takes priority over a same-cycle handshake.
REQ-029 start while not IDLE SHALL be ignored.
REQ-030 rom_period SHALL hold its last value outside FETCH.

Reset
REQ-031 rst_n=0 SHALL asynchronously force IDLE and zero key, key_period, rom_period, key_valid, key_last, busy, done, err and all counters.
REQ-032 Reset mid-sequence SHALL discard the sequence; after release the block SHALL await a new start.

Structure
REQ-033 Package odo_key_pkg SHALL hold NUM_PERIODS=9, PERIOD_MAX=8, KEY_W, PERIOD_W and the state enumeration.
REQ-034 Sub-module odo_period_counter (mod-9 load/increment counter) SHALL provide the period index; the key ROM stays outside this block.

Verification
Bench ROM model, registered, 1-cycle latency: p0=0x343, p1=0x227, p7=0x1d6, p8=0x046.
REQ-035 start, base_period=7, num_rounds=3, key_ready=1 -> keys 0x1d6/p7, 0x046/p8, then 0x343/p0 with key_last; first key_valid 3 cycles after start; done pulses one cycle after the third handshake.
REQ-036 base_period=0, num_rounds=2, key_ready=0 for 5 cycles -> key_valid=1, key=0x343, key_period=0 stable all 5 cycles; second key 0x227 3 cycles after ready rises.
REQ-037 start with base_period=9 -> err pulses for exactly 1 cycle; busy, key_valid and rom_period stay unchanged.
REQ-038 start, base_period=1, num_rounds=0 -> done pulses next cycle; key_valid never asserts.
REQ-039 abort during WAIT of round 1 of 4 -> IDLE next cycle, key_valid=0, busy=0, no done; a following start, base_period=8, num_rounds=1 returns 0x046 with key_last.
REQ-040 rst_n low during PRESENT -> all outputs 0 immediately without a clock edge; a start after release behaves as in REQ-035.

Source files
------------

// File: rtl/odo_key_pkg.sv
// Shared constants and FSM state codes for the round-key sequencer.
package odo_key_pkg;

  // Key schedule periods are numbered 0..PERIOD_MAX and wrap.
  localparam int NUM_PERIODS = 9;
  localparam int PERIOD_MAX  = NUM_PERIODS - 1;

  // Default datapath widths.
  localparam int KEY_W    = 10;
  localparam int PERIOD_W = 4;

  // Sequencer state encoding.
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_FETCH   = 3'd1;
  localparam state_t S_WAIT    = 3'd2;
  localparam state_t S_PRESENT = 3'd3;
  localparam state_t S_DONE    = 3'd4;

endpackage

// File: rtl/odo_period_counter.sv
// Modulo-9 period index counter with synchronous load and increment.
// Load wins over increment. period_next is the wrapped successor of the
// current value, which lets the sequencer drive the ROM address for the
// next round on the same edge the counter advances.
module odo_period_counter #(
  parameter int PERIOD_W = odo_key_pkg::PERIOD_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [PERIOD_W-1:0] load_value,
  input  logic                inc,
  output logic [PERIOD_W-1:0] period,
  output logic [PERIOD_W-1:0] period_next
);
  import odo_key_pkg::*;

  // Wrapped successor: PERIOD_MAX rolls back to period 0.
  assign period_next = (period == PERIOD_W'(PERIOD_MAX)) ? '0 : period + 1'b1;

  // Period register: load a new base or step to the successor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values; blocking here would create order races.
      period <= '0;
    end else if (load) begin
      period <= load_value;
    end else if (inc) begin
      period <= period_next;
    end
  end

endmodule

// File: rtl/odo_round_key_sequencer.sv
// Round-key sequencer: walks the external registered key ROM starting at a
// base period, presents one key per round through a valid/ready handshake,
// and flags the final key. The ROM address is registered on entry to FETCH,
// so the ROM data is settled by the time WAIT captures it.
module odo_round_key_sequencer #(
  parameter int KEY_W    = odo_key_pkg::KEY_W,
  parameter int PERIOD_W = odo_key_pkg::PERIOD_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [PERIOD_W-1:0] base_period,
  input  logic [4:0]          num_rounds,
  input  logic                abort,
  output logic [PERIOD_W-1:0] rom_period,
  input  logic [KEY_W-1:0]    rom_key,
  output logic [KEY_W-1:0]    key,
  output logic [PERIOD_W-1:0] key_period,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                key_last,
  output logic                busy,
  output logic                done,
  output logic                err
);
  import odo_key_pkg::*;

  state_t              state;
  logic [4:0]          rounds_total;
  logic [4:0]          round_idx;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] period_next;

  logic period_ok;
  logic accept;
  logic handshake;
  logic advance;

  assign period_ok = (base_period <= PERIOD_W'(PERIOD_MAX));
  assign accept    = (state == S_IDLE) && start && period_ok && (num_rounds != 5'd0);
  // Abort beats a same-cycle handshake, so the handshake is qualified here.
  assign handshake = (state == S_PRESENT) && key_valid && key_ready && !abort;
  assign advance   = handshake && !key_last;

  odo_period_counter #(
    .PERIOD_W (PERIOD_W)
  ) u_period_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (accept),
    .load_value  (base_period),
    .inc         (advance),
    .period      (period),
    .period_next (period_next)
  );

  // Sequencer FSM together with the registered outputs it owns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rom_period   <= '0;
      key          <= '0;
      key_period   <= '0;
      key_valid    <= 1'b0;
      key_last     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      rounds_total <= '0;
      round_idx    <= '0;
    end else begin
      // done and err are single-cycle pulses unless re-asserted below.
      done <= 1'b0;
      err  <= 1'b0;

      if ((state != S_IDLE) && abort) begin
        state     <= S_IDLE;
        key_valid <= 1'b0;
        key_last  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (!period_ok) begin
                err <= 1'b1;
              end else if (num_rounds == 5'd0) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state        <= S_FETCH;
                busy         <= 1'b1;
                rounds_total <= num_rounds;
                round_idx    <= '0;
                rom_period   <= base_period;
              end
            end
          end

          // Address is already on rom_period; give the ROM its cycle.
          S_FETCH: begin
            state <= S_WAIT;
          end

          S_WAIT: begin
            key        <= rom_key;
            key_period <= period;
            key_last   <= (round_idx == rounds_total - 5'd1);
            key_valid  <= 1'b1;
            state      <= S_PRESENT;
          end

          S_PRESENT: begin
            if (handshake) begin
              key_valid <= 1'b0;
              key_last  <= 1'b0;
              if (key_last) begin
                state <= S_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state      <= S_FETCH;
                round_idx  <= round_idx + 5'd1;
                rom_period <= period_next;
              end
            end
          end

          S_DONE: begin
            state <= S_IDLE;
          end

          default: begin
            state     <= S_IDLE;
            key_valid <= 1'b0;
            key_last  <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_odo_round_key_sequencer.sv
// Self-checking bench for odo_round_key_sequencer: a registered key ROM
// model, a table of directed sequences, hand-written corner cases (stall,
// abort, reset) and randomized sequences checked against a transaction-level
// model of the expected key stream.
module tb_odo_round_key_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] base_period;
  logic [4:0] num_rounds;
  logic       abort;
  logic [3:0] rom_period;
  logic [9:0] rom_key;
  logic [9:0] key;
  logic [3:0] key_period;
  logic       key_valid;
  logic       key_ready;
  logic       key_last;
  logic       busy;
  logic       done;
  logic       err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Key ROM contents per period (entries above 8 are never addressed).
  logic [9:0] rom_tab [16] = '{10'h343, 10'h227, 10'h0a5, 10'h1f0, 10'h31c,
                               10'h08e, 10'h2b9, 10'h1d6, 10'h046,
                               10'h000, 10'h000, 10'h000, 10'h000,
                               10'h000, 10'h000, 10'h000};

  odo_round_key_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_period (base_period),
    .num_rounds  (num_rounds),
    .abort       (abort),
    .rom_period  (rom_period),
    .rom_key     (rom_key),
    .key         (key),
    .key_period  (key_period),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_last    (key_last),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ROM, one cycle of latency.
  initial rom_key = '0;
  always @(posedge clk) rom_key <= rom_tab[rom_period];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected presentation for round i of a sequence starting at base.
  function automatic logic [15:0] model_present(input int base, input int n, input int i);
    int p;
    p = (base + i) % 9;
    return {1'b1, rom_tab[4'(p)], 4'(p), (i == n - 1)};
  endfunction

  // Issue one start and follow the sequence to completion.
  task automatic run_seq(input int base, input int n, input int pct,
                         output int first_key, output int last_period);
    logic [3:0]  rp_before;
    logic [15:0] exp_pres;
    int          lat;
    int          tries;
    first_key   = 0;
    last_period = 0;
    rp_before   = rom_period;
    base_period = 4'(base);
    num_rounds  = 5'(n);
    start       = 1'b1;
    step();
    start       = 1'b0;

    if (base > 8) begin
      check("err_pulse", 32'(err), 32'd1);
      check("err_state", 32'({busy, key_valid, rom_period}), 32'({2'b00, rp_before}));
      step();
      check("err_clear", 32'({err, busy}), 32'd0);
      return;
    end
    if (n == 0) begin
      check("zero_done", 32'({done, busy, key_valid}), 32'b100);
      step();
      check("zero_clear", 32'({done, key_valid}), 32'd0);
      return;
    end
    check("busy_start", 32'({busy, key_valid, done}), 32'b100);

    for (int i = 0; i < n; i++) begin
      lat = 0;
      while (!key_valid && lat < 10) begin
        step();
        lat++;
        if (done) check("early_done", 32'(done), 32'd0);
      end
      check("latency", 32'(lat), 32'd2);
      if (!key_valid) return;
      exp_pres = model_present(base, n, i);
      check("present", 32'({key_valid, key, key_period, key_last}), 32'(exp_pres));
      if (i == 0) first_key = int'(key);
      last_period = int'(key_period);
      tries = 0;
      key_ready = ($urandom_range(99) < pct);
      while (!key_ready) begin
        step();
        tries++;
        check("hold", 32'({key_valid, key, key_period, key_last}), 32'(exp_pres));
        key_ready = (tries >= 6) || ($urandom_range(99) < pct);
      end
      step();
      key_ready = 1'b0;
    end
    check("done_pulse", 32'({done, busy, key_valid}), 32'b100);
    step();
    check("done_clear", 32'(done), 32'd0);
  endtask

  typedef struct {
    int base;
    int n;
    int pct;
    int exp_first_key;
    int exp_last_period;
  } vec_t;

  vec_t vecs [7];
  int   fk;
  int   lp;

  initial begin
    vecs[0] = '{7,  3, 100, 32'h1d6, 0};
    vecs[1] = '{0,  2,  60, 32'h343, 1};
    vecs[2] = '{9,  2, 100, 0,       0};
    vecs[3] = '{1,  0, 100, 0,       0};
    vecs[4] = '{8,  1, 100, 32'h046, 8};
    vecs[5] = '{3, 12,  80, 32'h1f0, 5};
    vecs[6] = '{15, 1, 100, 0,       0};

    rst_n = 1'b0; start = 1'b0; base_period = '0; num_rounds = '0;
    abort = 1'b0; key_ready = 1'b0;
    #12;
    check("reset_outputs",
          32'({key, key_period, rom_period, key_valid, key_last, busy, done, err}), 32'd0);
    #3 rst_n = 1'b1;
    step();
    check("idle_after_reset", 32'({busy, key_valid, done, err}), 32'd0);

    // Directed table.
    for (int v = 0; v < 7; v++) begin
      run_seq(vecs[v].base, vecs[v].n, vecs[v].pct, fk, lp);
      check("tbl_first_key", 32'(fk), 32'(vecs[v].exp_first_key));
      check("tbl_last_period", 32'(lp), 32'(vecs[v].exp_last_period));
      step();
    end

    // Stall: key held for 5 cycles, start ignored meanwhile, then second key.
    base_period = 4'd0; num_rounds = 5'd2; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    for (int c = 0; c < 5; c++) begin
      check("stall_hold", 32'({key_valid, key, key_period, key_last}), 32'({1'b1, 10'h343, 4'd0, 1'b0}));
      start = 1'b1; base_period = 4'd5; num_rounds = 5'd7;
      step();
    end
    start = 1'b0;
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
    check("stall_gap0", 32'(key_valid), 32'd0);
    step();
    check("stall_gap1", 32'(key_valid), 32'd0);
    step();
    check("stall_second", 32'({key_valid, key, key_period, key_last}), 32'({1'b1, 10'h227, 4'd1, 1'b1}));
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
    check("stall_done", 32'({done, busy}), 32'b10);
    step();

    // Abort during WAIT of the second round of a 4-round sequence.
    base_period = 4'd2; num_rounds = 5'd4; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    check("abort_first", 32'({key_valid, key}), 32'({1'b1, 10'h0a5}));
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_idle", 32'({key_valid, busy, done}), 32'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      check("abort_quiet", 32'({key_valid, busy, done}), 32'd0);
    end
    run_seq(8, 1, 100, fk, lp);
    check("abort_restart", 32'({fk[9:0], lp[3:0]}), 32'({10'h046, 4'd8}));
    step();

    // Abort wins over a same-cycle handshake.
    base_period = 4'd4; num_rounds = 5'd1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    key_ready = 1'b1; abort = 1'b1;
    step();
    key_ready = 1'b0; abort = 1'b0;
    check("abort_vs_hs", 32'({key_valid, busy, done}), 32'd0);
    step();
    check("abort_vs_hs_nodone", 32'(done), 32'd0);

    // Asynchronous reset during PRESENT.
    base_period = 4'd7; num_rounds = 5'd3; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    check("pre_reset_valid", 32'(key_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset",
          32'({key, key_period, rom_period, key_valid, key_last, busy, done, err}), 32'd0);
    step();
    #2 rst_n = 1'b1;
    step();
    check("post_reset_idle", 32'({key_valid, busy, done}), 32'd0);
    run_seq(7, 3, 100, fk, lp);
    check("post_reset_seq", 32'({fk[9:0], lp[3:0]}), 32'({10'h1d6, 4'd0}));
    step();

    // Randomized sequences against the transaction-level model.
    for (int r = 0; r < 25; r++) begin
      run_seq(int'($urandom_range(10)), int'($urandom_range(6)), int'($urandom_range(100, 30)), fk, lp);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog against a stuck sequence.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
